core_data_wb_bridge: RTL and testbench
======================================

Name: core_data_wb_bridge

Overview:
Converts the core's custom data-memory port (req/wen/wmask/stall/err) into one pipelined-Wishbone master transaction at a time. The bridge sits between the core data port and the data-memory Wishbone bus (data_mem_*), which feeds the controller through the one-cycle ack/data register stage. It holds the core stalled until ack, err or timeout, then returns read data or an error for exactly one cycle. One transaction is outstanding at most; there is no write buffering.

Parameters:
ADDR_WIDTH, 32, width of core and Wishbone address
DATA_WIDTH, 32, width of the data buses; the select width is DATA_WIDTH/8
TIMEOUT_CYCLES, 1024, cycles waited for ack/err after issue before aborting; 0 disables the timeout

Ports:
clk_i  in  1  core clock
reset_i  in  1  synchronous, active-high reset
data_req_i  in  1  core requests a data access
data_wen_i  in  1  1 = write, 0 = read
data_wmask_i  in  DATA_WIDTH/8  byte write mask
data_addr_i  in  ADDR_WIDTH  access address
data_i  in  DATA_WIDTH  write data from core
data_o  out  DATA_WIDTH  read data to core
data_stall_o  out  1  core must hold its request while high
data_err_o  out  1  access error, valid in the response cycle
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe
wb_we_o  out  1  Wishbone write enable
wb_sel_o  out  DATA_WIDTH/8  byte selects
wb_addr_o  out  ADDR_WIDTH  address
wb_data_o  out  DATA_WIDTH  write data
wb_data_i  in  DATA_WIDTH  read data
wb_ack_i  in  1  acknowledge
wb_err_i  in  1  bus error
wb_stall_i  in  1  slave not accepting the strobe

Behaviour:
- Reset (synchronous, active-high, overrides everything):
  - State goes to IDLE.
  - All outputs are 0, including data_o, wb_addr_o and wb_data_o.
  - An in-flight transaction is dropped. wb_cyc_o is low in the cycle after reset is sampled.
- IDLE:
  - data_stall_o = data_req_i (combinational); cyc and stb are low.
  - On data_req_i: latch addr, wdata, we and sel, then go to ISSUE.
  - sel = data_wmask_i for writes, all-ones for reads.
- ISSUE:
  - cyc=1, stb=1, data_stall_o=1, and we/sel/addr/data are driven from the latches.
  - If wb_stall_i=0, the strobe is accepted:
    - with ack or err in the same cycle, go to RESP;
    - otherwise go to WAIT.
  - If wb_stall_i=1, remain in ISSUE with stb held. The timeout does not count here.
- WAIT:
  - cyc=1, stb=0, data_stall_o=1, and the timeout counter increments every cycle.
  - wb_ack_i: capture wb_data_i (reads only; writes leave data_o unchanged), clear the error flag, go to RESP.
  - wb_err_i: set the error flag, go to RESP. If ack and err occur together, err wins.
  - Counter reaching TIMEOUT_CYCLES with neither: set the error flag, go to RESP.
- RESP (exactly one cycle):
  - cyc=0, data_stall_o=0, data_err_o = error flag, data_o = captured data.
  - Return to IDLE unconditionally. A new request is seen in IDLE on the next cycle.
  - data_err_o is 0 outside RESP.
- Latency: a read with zero wb_stall and ack N cycles after the strobe is accepted completes in RESP N+2 cycles after req is seen in IDLE. Minimum per transaction is 3 cycles (IDLE, ISSUE, RESP).
- Stray acks or errs in IDLE or RESP (e.g. arriving late through the registered ack stage after a timeout) are ignored and change no state.
- Core inputs are ignored outside IDLE because the latched copies are used. The core must hold req until it sees stall low.
- Timeout counter: width $clog2(TIMEOUT_CYCLES+1), cleared on entry to ISSUE, saturating.

Decomposition:
- Package core_wb_bridge_pkg:
  - state enum {IDLE, ISSUE, WAIT, RESP};
  - SEL_ALL constant;
  - localparam function for the counter width.
- Sub-module wb_timeout_counter (enable, clear, expired; parameter LIMIT, where 0 means never expires).
- FSM and latches stay in core_data_wb_bridge.

Test Plan:
- Reset, then read addr 0x100, slave ack 2 cycles after strobe with data 0xDEADBEEF -> stb high exactly 1 cycle, sel=4'hF, we=0. RESP 4 cycles after req with data_o=0xDEADBEEF, err=0, stall low for 1 cycle.
- Write addr 0x204, data 0x12345678, wmask 4'b0011, wb_stall_i high 3 cycles -> stb held 4 cycles with stable addr/data/sel=4'b0011, then completes on ack; data_o unchanged.
- Read with wb_err_i after 1 cycle -> data_err_o=1 in RESP only, cyc low that cycle. The next read returns err=0.
- TIMEOUT_CYCLES=8, slave never acks -> cyc drops after 8 WAIT cycles, err=1. A late ack 1 cycle after RESP is ignored (state stays IDLE, no response).
- Back-to-back: two reads, core re-asserts req the cycle after RESP -> second strobe appears 1 cycle after IDLE. Both data values returned in order.
- Assert reset_i during WAIT -> next cycle cyc=0, stall=0, all outputs 0. The subsequent ack is ignored.

Source files
------------

// File: rtl/core_wb_bridge_pkg.sv
// rtl/core_wb_bridge_pkg.sv - shared types and constants for the core data Wishbone bridge
//
// Purpose: state encoding, all-lanes byte select and timeout counter sizing
// shared by core_data_wb_bridge and wb_timeout_counter.
// Ports: none (package).
package core_wb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } bridge_state_t;

    // Wide enough for any practical bus; users slice the low DATA_WIDTH/8 bits.
    localparam logic [127:0] SEL_ALL = '1;

    // Counter must hold 0..limit; a disabled timeout (0) still gets one bit.
    function automatic int timeout_cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// rtl/wb_timeout_counter.sv - saturating wait-cycle counter with expiry flag
//
// Purpose: counts cycles while enabled and flags the cycle in which the
// LIMIT-th enabled cycle is reached, so the owner can leave that same cycle.
// LIMIT = 0 disables expiry entirely.
//
// Ports:
//   clk_i, reset_i  clock, synchronous active-high reset
//   enable          count this cycle
//   clear           restart from zero
//   expired         this enabled cycle is the LIMIT-th one (combinational)
module wb_timeout_counter
    import core_wb_bridge_pkg::*;
#(
    parameter int LIMIT = 1024
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int W = timeout_cnt_width(LIMIT);

    generate
        if (LIMIT == 0) begin : g_never
            assign expired = 1'b0;
        end else begin : g_count
            localparam logic [W-1:0] LAST = W'(LIMIT - 1);
            localparam logic [W-1:0] SAT  = W'(LIMIT);

            logic [W-1:0] count;

            always_ff @(posedge clk_i) begin
                if (reset_i || clear) begin
                    count <= '0;
                end else if (enable && (count != SAT)) begin
                    count <= count + W'(1);
                end
            end

            // count holds the number of earlier enabled cycles, so the current
            // one is the LIMIT-th when count has reached LIMIT-1.
            assign expired = enable && (count >= LAST);
        end
    endgenerate

endmodule

// File: rtl/core_data_wb_bridge.sv
// rtl/core_data_wb_bridge.sv - core data port to pipelined Wishbone master bridge
//
// Purpose: turns one core data-port request at a time into a single pipelined
// Wishbone transaction, keeps the core stalled until ack, err or timeout, then
// presents read data / error for exactly one cycle. No write buffering.
//
// Ports:
//   clk_i, reset_i   core clock, synchronous active-high reset
//   data_req_i       core access request (held until stall seen low)
//   data_wen_i       1 = write, 0 = read
//   data_wmask_i     byte write mask
//   data_addr_i      access address
//   data_i           write data from core
//   data_o           captured read data (valid in the response cycle)
//   data_stall_o     core must hold its request while high
//   data_err_o       access error, only in the response cycle
//   wb_cyc_o/stb_o   Wishbone cycle / strobe
//   wb_we_o/sel_o    Wishbone write enable / byte selects
//   wb_addr_o        Wishbone address
//   wb_data_o        Wishbone write data
//   wb_data_i        Wishbone read data
//   wb_ack_i/err_i   Wishbone acknowledge / bus error
//   wb_stall_i       slave not accepting the strobe
module core_data_wb_bridge
    import core_wb_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    data_req_i,
    input  logic                    data_wen_i,
    input  logic [DATA_WIDTH/8-1:0] data_wmask_i,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic [DATA_WIDTH-1:0]   data_i,
    output logic [DATA_WIDTH-1:0]   data_o,
    output logic                    data_stall_o,
    output logic                    data_err_o,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    output logic [ADDR_WIDTH-1:0]   wb_addr_o,
    output logic [DATA_WIDTH-1:0]   wb_data_o,
    input  logic [DATA_WIDTH-1:0]   wb_data_i,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i,
    input  logic                    wb_stall_i
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    bridge_state_t          state;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [DATA_WIDTH-1:0]  rdata_q;
    logic [SEL_WIDTH-1:0]   sel_q;
    logic                   we_q;
    logic                   err_q;

    logic to_enable;
    logic to_clear;
    logic to_expired;
    logic bus_live;

    assign to_enable = (state == WAIT);
    assign to_clear  = (state == IDLE) && data_req_i;

    // ack/err only mean something once the strobe has been accepted: in ISSUE
    // that is the cycle the slave drops stall, in WAIT it is every cycle.
    assign bus_live = (state == WAIT) || ((state == ISSUE) && !wb_stall_i);

    wb_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .enable  (to_enable),
        .clear   (to_clear),
        .expired (to_expired)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_req_i) begin
                        addr_q  <= data_addr_i;
                        wdata_q <= data_i;
                        we_q    <= data_wen_i;
                        sel_q   <= data_wen_i ? data_wmask_i : SEL_ALL[SEL_WIDTH-1:0];
                        state   <= ISSUE;
                    end
                end
                ISSUE, WAIT: begin
                    if (bus_live) begin
                        // err has priority over a simultaneous ack
                        if (wb_err_i) begin
                            err_q <= 1'b1;
                            state <= RESP;
                        end else if (wb_ack_i) begin
                            if (!we_q) begin
                                rdata_q <= wb_data_i;
                            end
                            err_q <= 1'b0;
                            state <= RESP;
                        end else if (state == ISSUE) begin
                            state <= WAIT;
                        end else if (to_expired) begin
                            err_q <= 1'b1;
                            state <= RESP;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign wb_cyc_o  = (state == ISSUE) || (state == WAIT);
    assign wb_stb_o  = (state == ISSUE);
    assign wb_we_o   = we_q;
    assign wb_sel_o  = sel_q;
    assign wb_addr_o = addr_q;
    assign wb_data_o = wdata_q;

    assign data_o       = rdata_q;
    assign data_err_o   = (state == RESP) && err_q;
    // In IDLE the stall follows req directly so the core holds its request
    // through the latch cycle; only the response cycle releases it.
    assign data_stall_o = (state == IDLE) ? data_req_i : (state != RESP);

endmodule

// File: tb/tb_core_data_wb_bridge.sv
// tb/tb_core_data_wb_bridge.sv - self-checking bench for core_data_wb_bridge
module tb_core_data_wb_bridge;

    localparam int NC = 200;
    localparam int TO = 8;
    localparam int K_ACK = 0, K_ERR = 1, K_NONE = 2, K_BOTH = 3, K_RST = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_i, data_req_i, data_wen_i;
    logic [3:0]  data_wmask_i;
    logic [31:0] data_addr_i, data_i, data_o;
    logic        data_stall_o, data_err_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_addr_o, wb_data_o, wb_data_i;
    logic        wb_ack_i, wb_err_i, wb_stall_i;

    core_data_wb_bridge #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .data_req_i   (data_req_i),
        .data_wen_i   (data_wen_i),
        .data_wmask_i (data_wmask_i),
        .data_addr_i  (data_addr_i),
        .data_i       (data_i),
        .data_o       (data_o),
        .data_stall_o (data_stall_o),
        .data_err_o   (data_err_o),
        .wb_cyc_o     (wb_cyc_o),
        .wb_stb_o     (wb_stb_o),
        .wb_we_o      (wb_we_o),
        .wb_sel_o     (wb_sel_o),
        .wb_addr_o    (wb_addr_o),
        .wb_data_o    (wb_data_o),
        .wb_data_i    (wb_data_i),
        .wb_ack_i     (wb_ack_i),
        .wb_err_i     (wb_err_i),
        .wb_stall_i   (wb_stall_i)
    );

    typedef struct {
        bit          wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [31:0] rdata;
        int          stalls;
        int          kind;
        int          dly;
        int          gap;
        bit          late;
    } txn_t;

    txn_t tx[11];

    // per-cycle stimulus
    bit          d_rst[NC], d_req[NC], d_wen[NC], d_ack[NC], d_err[NC], d_wbst[NC];
    logic [3:0]  d_mask[NC];
    logic [31:0] d_addr[NC], d_wdata[NC], d_rdata[NC];
    // per-cycle expectations
    bit          e_valid[NC], e_zero[NC], e_cyc[NC], e_stb[NC], e_stall[NC], e_err[NC];
    bit          e_bus[NC], e_wchk[NC], e_dchk[NC], e_we[NC];
    logic [3:0]  e_sel[NC];
    logic [31:0] e_addr[NC], e_wdata[NC], e_data[NC];

    int cyc_no  = 0;
    bit running = 1'b0;
    int total   = 0;
    int bad     = 0;
    int cyc_run = 0, stb_run = 0, nrun = 0, n_errp = 0, nresp = 0;
    int run_cyc[16], run_stb[16];
    logic [31:0] resp_data[16];

    function automatic txn_t mk(input bit wen, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] mask, input logic [31:0] rdata, input int stalls,
                                input int kind, input int dly, input int gap, input bit late);
        txn_t t;
        t.wen = wen; t.addr = addr; t.wdata = wdata; t.mask = mask; t.rdata = rdata;
        t.stalls = stalls; t.kind = kind; t.dly = dly; t.gap = gap; t.late = late;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle %0d: got %0h want %0h", name, cyc_no, act, exp);
        end
    endtask

    task automatic apply(input int c);
        reset_i      = d_rst[c];
        data_req_i   = d_req[c];
        data_wen_i   = d_wen[c];
        data_wmask_i = d_mask[c];
        data_addr_i  = d_addr[c];
        data_i       = d_wdata[c];
        wb_data_i    = d_rdata[c];
        wb_ack_i     = d_ack[c];
        wb_err_i     = d_err[c];
        wb_stall_i   = d_wbst[c];
    endtask

    // Timeline model: each transaction is laid out from the latency rules
    // (req seen at t0, strobe accepted at ta, slave answer at ta+dly, response
    // one cycle later, or 8 wait cycles then response on timeout).
    initial begin
        int t0, ta, fin, endc, c;
        logic [31:0] last;
        txn_t t;

        tx[0]  = mk(0, 32'h100, 32'h0,        4'h0,    32'hDEADBEEF, 0, K_ACK,  2, 2, 0);
        tx[1]  = mk(1, 32'h204, 32'h12345678, 4'b0011, 32'h0,        3, K_ACK,  1, 1, 0);
        tx[2]  = mk(0, 32'h300, 32'h0,        4'h0,    32'h99999999, 0, K_ERR,  1, 1, 0);
        tx[3]  = mk(0, 32'h304, 32'h0,        4'h0,    32'hCAFEF00D, 0, K_ACK,  0, 1, 0);
        tx[4]  = mk(0, 32'h400, 32'h0,        4'h0,    32'h77777777, 0, K_NONE, 0, 1, 1);
        tx[5]  = mk(0, 32'h500, 32'h0,        4'h0,    32'h11112222, 0, K_ACK,  1, 3, 0);
        tx[6]  = mk(0, 32'h504, 32'h0,        4'h0,    32'h33334444, 0, K_ACK,  3, 0, 0);
        tx[7]  = mk(0, 32'h600, 32'h0,        4'h0,    32'h55556666, 0, K_BOTH, 1, 1, 0);
        tx[8]  = mk(1, 32'h208, 32'hA5A50F0F, 4'b1100, 32'h0,        1, K_ACK,  0, 1, 0);
        tx[9]  = mk(0, 32'h700, 32'h0,        4'h0,    32'h88889999, 0, K_RST,  2, 1, 0);
        tx[10] = mk(0, 32'h800, 32'h0,        4'h0,    32'h5A5A5A5A, 0, K_ACK,  1, 2, 0);

        for (int i = 0; i < NC; i++) begin
            d_mask[i] = '0; d_addr[i] = '0; d_wdata[i] = '0;
            d_rdata[i] = 32'h0BAD0000 | i;
            e_valid[i] = (i >= 1);
            e_sel[i] = '0; e_addr[i] = '0; e_wdata[i] = '0; e_data[i] = '0;
        end
        for (int i = 0; i < 3; i++) d_rst[i] = 1'b1;
        for (int i = 1; i < 4; i++) e_zero[i] = 1'b1;

        c = 4;
        last = '0;
        for (int k = 0; k < 11; k++) begin
            t  = tx[k];
            t0 = c + t.gap;
            ta = t0 + 1 + t.stalls;
            if (t.kind == K_RST)       fin = ta + t.dly;
            else if (t.kind == K_NONE) fin = ta + TO + 1;
            else                       fin = ta + t.dly + 1;

            // core holds req until it sees stall low; other inputs are
            // scrambled after t0 since the bridge must use its own copies
            for (int i = t0; i <= fin; i++) begin
                d_req[i]   = 1'b1;
                d_wen[i]   = (i == t0) ? t.wen   : !t.wen;
                d_mask[i]  = (i == t0) ? t.mask  : ~t.mask;
                d_addr[i]  = (i == t0) ? t.addr  : (t.addr ^ 32'hFFFF0000);
                d_wdata[i] = (i == t0) ? t.wdata : ~t.wdata;
            end
            for (int i = t0 + 1; i < ta; i++) d_wbst[i] = 1'b1;

            for (int i = t0; i <= fin; i++) begin
                if (i < fin || t.kind == K_RST) e_stall[i] = 1'b1;
                if (i > t0 && (i < fin || t.kind == K_RST)) begin
                    e_cyc[i]   = 1'b1;
                    e_stb[i]   = (i <= ta);
                    e_bus[i]   = 1'b1;
                    e_we[i]    = t.wen;
                    e_sel[i]   = t.wen ? t.mask : 4'hF;
                    e_addr[i]  = t.addr;
                    e_wchk[i]  = t.wen;
                    e_wdata[i] = t.wdata;
                end
            end

            if (t.kind == K_RST) begin
                d_rst[fin]       = 1'b1;
                e_zero[fin + 1]  = 1'b1;
                d_ack[fin + 1]   = 1'b1;
                d_ack[fin + 2]   = 1'b1;
                d_rdata[fin + 1] = t.rdata;
                d_rdata[fin + 2] = t.rdata;
                last = '0;
            end else begin
                if (t.kind == K_ACK || t.kind == K_BOTH) d_ack[ta + t.dly] = 1'b1;
                if (t.kind == K_ERR || t.kind == K_BOTH) d_err[ta + t.dly] = 1'b1;
                if (t.kind != K_NONE) d_rdata[ta + t.dly] = t.rdata;
                if (t.kind == K_ACK && !t.wen) last = t.rdata;
                e_err[fin]  = (t.kind != K_ACK);
                e_dchk[fin] = 1'b1;
                e_data[fin] = last;
                if (t.late) begin
                    d_ack[fin + 1]   = 1'b1;
                    d_rdata[fin + 1] = t.rdata;
                end
            end
            c = fin + 1;
        end
        endc = c + 4;

        apply(0);
        running = 1'b1;
        for (int i = 1; i < endc; i++) begin
            @(posedge clk);
            cyc_no = i;
            #1 apply(i);
        end
        @(negedge clk);
        #1 running = 1'b0;

        // hand-derived figures for selected transactions
        chk("t1_stb_len",   run_stb[0], 1);
        chk("t1_cyc_len",   run_cyc[0], 3);
        chk("t1_data",      resp_data[0], 32'hDEADBEEF);
        chk("t2_stb_len",   run_stb[1], 4);
        chk("t2_data_kept", resp_data[1], 32'hDEADBEEF);
        chk("t5_cyc_len",   run_cyc[4], 9);
        chk("t7_data",      resp_data[6], 32'h33334444);
        chk("t8_data_kept", resp_data[7], 32'h33334444);
        chk("t10_cyc_len",  run_cyc[9], 3);
        chk("cyc_runs",     nrun, 11);
        chk("err_pulses",   n_errp, 3);
        chk("resp_count",   nresp, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    always @(negedge clk) begin
        if (running) begin
            automatic int c = cyc_no;
            if (wb_cyc_o === 1'b1) begin
                cyc_run++;
                if (wb_stb_o === 1'b1) stb_run++;
            end else if (cyc_run > 0) begin
                if (nrun < 16) begin
                    run_cyc[nrun] = cyc_run;
                    run_stb[nrun] = stb_run;
                end
                nrun++;
                cyc_run = 0;
                stb_run = 0;
            end
            if (data_err_o === 1'b1) n_errp++;

            if (e_valid[c]) begin
                if (e_zero[c]) begin
                    chk("rst_data_o",  data_o,    32'h0);
                    chk("rst_we",      wb_we_o,   1'b0);
                    chk("rst_sel",     wb_sel_o,  4'h0);
                    chk("rst_addr",    wb_addr_o, 32'h0);
                    chk("rst_wdata",   wb_data_o, 32'h0);
                end
                chk("cyc",   wb_cyc_o,     e_cyc[c]);
                chk("stb",   wb_stb_o,     e_stb[c]);
                chk("stall", data_stall_o, e_stall[c]);
                chk("err",   data_err_o,   e_err[c]);
                if (e_bus[c]) begin
                    chk("we",   wb_we_o,   e_we[c]);
                    chk("sel",  wb_sel_o,  e_sel[c]);
                    chk("addr", wb_addr_o, e_addr[c]);
                    if (e_wchk[c]) chk("wdata", wb_data_o, e_wdata[c]);
                end
                if (e_dchk[c]) begin
                    chk("rdata", data_o, e_data[c]);
                    if (nresp < 16) resp_data[nresp] = data_o;
                    nresp++;
                end
            end
        end
    end

endmodule
